// File: rtl/r200_hazard_ctrl.sv
// r200_hazard_ctrl: ID-stage hazard scoreboard, jump flush sequencer and stall counter
// Ports:
//    clk, rst                        clock, synchronous active-high reset
//    id_valid, id_rs1addr/use        ID instruction validity and first source
//    id_rs2addr/use                  second source
//    id_regwr, id_rdaddr             ID destination write
//    id_willjmp                      ID instruction is a taken branch or jump
//    wb_regwr, wb_rdaddr             writeback retire
//    stall_id, bubble_ex, issue      combinational pipeline controls
//    flush_if                        registered one-cycle IF kill after an issued jump
//    sb_err                          sticky retire-without-pending error
//    stall_cnt                       saturating count of stalled cycles
module r200_hazard_ctrl #(
   parameter int NREG  = 32,
   parameter int CNTW  = 2,
   parameter int PERFW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1addr,
   input  logic             id_rs1use,
   input  logic [4:0]       id_rs2addr,
   input  logic             id_rs2use,
   input  logic             id_regwr,
   input  logic [4:0]       id_rdaddr,
   input  logic             id_willjmp,
   input  logic             wb_regwr,
   input  logic [4:0]       wb_rdaddr,
   output logic             stall_id,
   output logic             bubble_ex,
   output logic             flush_if,
   output logic             issue,
   output logic             sb_err,
   output logic [PERFW-1:0] stall_cnt
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t state, state_nx;
   logic [CNTW-1:0] pend [NREG];
   logic v, hit1, hit2, hitw, ret_err;
   always_comb begin
      v = id_valid && state == RUN;
      hit1 = id_rs1use && id_rs1addr != 5'd0 && pend[id_rs1addr] != '0;
      hit2 = id_rs2use && id_rs2addr != 5'd0 && pend[id_rs2addr] != '0;
      hitw = id_regwr && id_rdaddr != 5'd0 && pend[id_rdaddr] == '1;
      stall_id = v && (hit1 || hit2 || hitw);
      bubble_ex = stall_id;
      issue = v && !stall_id;
      state_nx = state == RUN && issue && id_willjmp ? FLUSH : RUN;
      // a retire cancelled by a same-register issue is legal even at count 0
      ret_err = wb_regwr && wb_rdaddr != 5'd0 && pend[wb_rdaddr] == '0 &&
                !(issue && id_regwr && id_rdaddr == wb_rdaddr);
   end
   assign flush_if = state == FLUSH;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         sb_err <= 1'b0;
         stall_cnt <= '0;
         for (int r = 0; r < NREG; r++) pend[r] <= '0;
      end else begin
         state <= state_nx;
         if (ret_err) sb_err <= 1'b1;
         if (stall_id && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         for (int r = 1; r < NREG; r++) begin
            if (issue && id_regwr && id_rdaddr == 5'(r) && !(wb_regwr && wb_rdaddr == 5'(r)))
               pend[r] <= pend[r] + 1'b1;
            else if (wb_regwr && wb_rdaddr == 5'(r) && !(issue && id_regwr && id_rdaddr == 5'(r)) && pend[r] != '0)
               pend[r] <= pend[r] - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_r200_hazard_ctrl.sv
// tb_r200_hazard_ctrl: directed plus random stimulus checked against a behavioural scoreboard model
module tb_r200_hazard_ctrl;
   logic clk = 0, rst = 1;
   logic id_valid = 0, id_rs1use = 0, id_rs2use = 0, id_regwr = 0, id_willjmp = 0, wb_regwr = 0;
   logic [4:0] id_rs1addr = 0, id_rs2addr = 0, id_rdaddr = 0, wb_rdaddr = 0;
   logic stall_id, bubble_ex, flush_if, issue, sb_err;
   logic [15:0] stall_cnt;
   int n_chk = 0, n_fail = 0;
   int m_pend [32];
   bit m_flush, m_err;
   int m_cnt;

   r200_hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1addr(id_rs1addr), .id_rs1use(id_rs1use),
      .id_rs2addr(id_rs2addr), .id_rs2use(id_rs2use), .id_regwr(id_regwr), .id_rdaddr(id_rdaddr),
      .id_willjmp(id_willjmp), .wb_regwr(wb_regwr), .wb_rdaddr(wb_rdaddr), .stall_id(stall_id),
      .bubble_ex(bubble_ex), .flush_if(flush_if), .issue(issue), .sb_err(sb_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_flush = 0;
      m_err = 0;
      m_cnt = 0;
   endtask

   task automatic step(input bit r, input bit v, input int a1, input bit u1, input int a2, input bit u2,
                       input bit w, input int rd, input bit j, input bit wr, input int wa);
      bit ve, es, ei;
      @(negedge clk);
      rst = r; id_valid = v; id_rs1addr = 5'(a1); id_rs1use = u1; id_rs2addr = 5'(a2); id_rs2use = u2;
      id_regwr = w; id_rdaddr = 5'(rd); id_willjmp = j; wb_regwr = wr; wb_rdaddr = 5'(wa);
      #1;
      ve = v && !m_flush;
      es = ve && ((u1 && a1 != 0 && m_pend[a1] > 0) || (u2 && a2 != 0 && m_pend[a2] > 0) ||
                  (w && rd != 0 && m_pend[rd] == 3));
      ei = ve && !es;
      check("stall_id", stall_id, es);
      check("bubble_ex", bubble_ex, es);
      check("issue", issue, ei);
      check("flush_if", flush_if, m_flush);
      check("sb_err", sb_err, m_err);
      check("stall_cnt", stall_cnt, m_cnt);
      if (r) model_reset();
      else begin
         if (es && m_cnt < 65535) m_cnt++;
         m_flush = ei && j;
         if (wr && wa != 0 && !(ei && w && rd == wa)) begin
            if (m_pend[wa] == 0) m_err = 1;
            else m_pend[wa]--;
         end
         if (ei && w && rd != 0 && !(wr && wa == rd)) m_pend[rd]++;
      end
   endtask

   task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      // reset state, plain issue
      step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      // RAW on x3, retired after a few stalled cycles
      step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      repeat (3) step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 3);
      step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      // jump flush writing x1
      step(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      // WAW saturation on x7
      repeat (3) step(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 7, 0, 1, 7);
      step(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      // simultaneous issue and retire on x9
      step(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 9, 0, 1, 9);
      step(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 9, 1, 0, 0, 0, 1, 9);
      step(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
      // retire error on x4, x0 never tracked
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
      step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0);
      idle();
      // reset mid-stall
      step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
      step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      // random traffic on a small register window
      for (int n = 0; n < 3000; n++) begin
         int wa, s;
         bit wr;
         wa = 0;
         wr = $urandom_range(0, 2) == 0;
         s = $urandom_range(1, 7);
         for (int k = 0; k < 7; k++)
            if (wa == 0 && m_pend[1 + (s + k) % 7] > 0) wa = 1 + (s + k) % 7;
         if (wa == 0 || $urandom_range(0, 19) == 0) wa = $urandom_range(0, 7);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7) == 0, wr, wa);
      end
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/r200_hazard_ctrl.md
Name: r200_hazard_ctrl

Overview:
Pipeline sequencing controller for the r200 decode (ID) stage. It tracks in-flight register writes in a per-register scoreboard. It stalls ID on read-after-write and write-after-write hazards against pending writebacks. It also sequences a one-cycle fetch flush after taken branches and jumps, and keeps a saturating stall counter.

Parameters:
NREG, 32, number of architectural GPRs tracked (x0 never tracked)
CNTW, 2, width of each per-register pending-write counter
PERFW, 16, width of the stall performance counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_rs1addr  input  5  instrn[19:15] of ID instruction
id_rs1use  input  1  instruction reads rs1
id_rs2addr  input  5  rs2 address after rs2addrsel mux
id_rs2use  input  1  instruction reads rs2
id_regwr  input  1  decoder regwr for ID instruction
id_rdaddr  input  5  destination address after wasel mux (may be x1)
id_willjmp  input  1  decoder willjmp (taken branch or jump)
wb_regwr  input  1  writeback stage writing regfile this cycle
wb_rdaddr  input  5  writeback destination
stall_id  output  1  hold PC and IF/ID register (combinational)
bubble_ex  output  1  inject NOP into ID/EX (combinational, equals stall_id)
flush_if  output  1  kill instruction in IF/ID (registered)
issue  output  1  ID instruction advances this cycle (combinational)
sb_err  output  1  sticky: retire to a non-pending register
stall_cnt  output  PERFW  cycles with stall_id=1, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - All pending counters := 0; state := RUN; flush_if := 0; sb_err := 0; stall_cnt := 0.
  - Combinational outputs follow from the cleared state, so stall_id=0 and issue=id_valid.
- States:
  - RUN: normal operation.
  - FLUSH: one cycle, flush_if=1.
- Effective valid: v = id_valid AND state==RUN. In FLUSH the ID instruction is a wrong-path fetch and is treated as invalid.
- Hazard, per source: hit1 = id_rs1use AND rs1!=0 AND pend[rs1]!=0. hit2 is the same test on rs2.
- WAW hazard: hitw = id_regwr AND rd!=0 AND pend[rd]==2^CNTW-1 (counter saturated).
- stall_id = v AND (hit1 OR hit2 OR hitw). issue = v AND NOT stall_id.
- A same-cycle wb retire does NOT clear a hazard. The regfile write lands at the edge, so the stall holds for that cycle and the next cycle sees the new value.
- Counter update at posedge, for each r != 0:
  - inc = issue AND id_regwr AND rd==r.
  - dec = wb_regwr AND wb_rdaddr==r.
  - inc AND dec: unchanged.
  - inc only: +1.
  - dec only with count>0: -1.
  - dec only with count==0: unchanged, and sb_err := 1.
- Writes to x0 are never tracked: no inc, no dec, no error.
- Transitions:
  - RUN to FLUSH when issue AND id_willjmp. flush_if is 1 in the following cycle only.
  - FLUSH to RUN always, after one cycle.
  - A jump cannot issue while stalled. It retries each cycle until the stall clears.
- stall_cnt: +1 each cycle stall_id=1; holds at 2^PERFW-1.
- Reset mid-operation: all pending state is discarded immediately. The stall deasserts in the cycle after the reset edge.

Test Plan:
- Reset, then id_valid=1, rs1=5 used, pend all 0 -> stall_id=0, issue=1, flush_if=0, stall_cnt=0.
- RAW stall:
  - Issue a write to x3, then next cycle an instruction reading rs1=x3 -> stall_id=1 every cycle until the cycle after wb_regwr=1 with wb_rdaddr=3; then issue=1.
  - stall_cnt equals the stalled cycle count.
- Jump flush:
  - Issue with id_willjmp=1, id_regwr=1, rd=1 -> next cycle flush_if=1, issue=0 even with id_valid=1.
  - The cycle after that, back in RUN; pend[1]=1.
- WAW saturation: three issues writing x7 with no retire -> fourth writer of x7 stalls. One wb retire of x7 -> next cycle it issues.
- Simultaneous issue and retire of x9 (pend[9]=1) -> pend[9] stays 1. A later reader of x9 stalls until one more retire.
- Error and x0:
  - wb_regwr to x4 with pend[4]=0 -> sb_err=1 and stays 1 until rst.
  - Issue writing x0 then a read of x0 -> no stall.
  - rst asserted mid-stall -> stall_id=0 in the cycle after the reset edge.
